spi_frame_sequencer: RTL and testbench
======================================

Name: spi_frame_sequencer

Overview:
- Controls the byte-level SPI slave datapath.
- Per SPI frame, it snapshots the synchronised sample inputs and supplies the transmit byte stream: sequence count, sample high byte, sample low byte, checksum, then pad bytes.
- It parses the first received byte of a frame as a control command that drives `ctrl` and the LED.
- It sits between the SPI byte shifter (which supplies frame and byte strobes) and the board sample pins.

Parameters:
- NBITS, 12, sample input width; legal range 9..16.
- PAD_BYTE, 8'hAA, byte sent after the checksum and whenever idle.

Ports:
- clk  input  1  system clock; the SPI shifter runs on the same clock.
- rst  input  1  synchronous, active-high reset.
- frame_start  input  1  1-cycle pulse when SSEL goes active.
- frame_end  input  1  1-cycle pulse when SSEL goes inactive.
- tx_req  input  1  1-cycle pulse; the shifter samples tx_byte in this cycle to start a byte.
- rx_valid  input  1  1-cycle pulse; rx_byte holds a complete received byte.
- rx_byte  input  8  received byte, MSB-first assembled.
- d_in  input  NBITS  asynchronous sample pins.
- tx_byte  output  8  byte presented to the shifter (registered).
- ctrl  output  7  control register written by command.
- led  output  1  equals ctrl[0].
- seq_cnt  output  8  completed-frame counter.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (synchronous, while rst=1):
  - tx_byte=PAD_BYTE, ctrl=0, led=0, seq_cnt=0, busy=0.
  - Snapshot, checksum and synchroniser registers = 0; state=IDLE.
  - Reset mid-frame abandons the frame; strobes are ignored until the next frame_start.
- Input sync: d_in passes through a 2-flop synchroniser; the snapshot register loads the synchronised value in the frame_start cycle.
- States: IDLE, HDR, DHI, DLO, CSUM, PAD.
  - IDLE: tx_byte=PAD_BYTE. tx_req and rx_valid are ignored.
  - On frame_start: state=HDR, busy=1, tx_byte<=seq_cnt, csum<=seq_cnt.
  - tx_req in HDR: next tx_byte<={(16-NBITS) zeros, snap[NBITS-1:8]}; state=DHI; csum^= that byte.
  - tx_req in DHI: tx_byte<=snap[7:0]; state=DLO; csum^= that byte.
  - tx_req in DLO: tx_byte<=csum (XOR of bytes 0..2); state=CSUM.
  - tx_req in CSUM: tx_byte<=PAD_BYTE; state=PAD.
  - PAD: tx_req holds PAD_BYTE indefinitely.
- tx_byte latency: new value is visible the cycle after tx_req. The shifter's next tx_req is at least 8 SCK edges later, so no overlap occurs.
- Command parse: only the first rx_valid after frame_start counts; later rx bytes in the frame are ignored.
  - If rx_byte[7]=1: ctrl<=rx_byte[6:0] on the next cycle, and led follows ctrl[0].
  - If rx_byte[7]=0: no-op (read-only frame).
- frame_end:
  - From any non-IDLE state: state=IDLE, busy=0, tx_byte<=PAD_BYTE, seq_cnt<=seq_cnt+1 (wraps 255->0).
  - In IDLE: ignored, with no increment.
- Short frame (frame_end before CSUM): seq_cnt still increments. The snapshot is discarded.
- Simultaneous events:
  - frame_end and frame_start in the same cycle: end processing first (seq_cnt increments), then start. The new header carries the incremented count and busy stays 1.
  - frame_start while busy without frame_end: restart at HDR with no seq_cnt increment.
  - tx_req and rx_valid in the same cycle: both are processed independently.
  - tx_req in the frame_start cycle: ignored. The shifter loads byte 0 from the registered tx_byte only after frame_start.
- Checksum width: 8-bit XOR, no carry.

Test Plan:
1. Reset, then frame with d_in=12'hA5C held 4+ cycles, seq_cnt=0, 5 tx_req -> tx_byte sequence 8'h00, 8'h0A, 8'h5C, 8'h56, 8'hAA; frame_end -> seq_cnt=1, busy=0.
2. Frame with first rx byte 8'h81 then 8'h80 -> ctrl=7'h01, led=1; the second byte is ignored. Next frame with first byte 8'h00 -> ctrl unchanged.
3. 256 back-to-back empty frames (start/end only) -> seq_cnt wraps to 0; header of frame 257 = 8'h00.
4. frame_end after 1 tx_req -> state IDLE, tx_byte=8'hAA, seq_cnt incremented; tx_req/rx_valid while idle -> no change to tx_byte or ctrl.
5. rst asserted in DLO state with ctrl=7'h15 -> next cycle all outputs at reset values; tx_req with no frame_start -> tx_byte stays 8'hAA.
6. Same-cycle frame_end+frame_start with seq_cnt=8'h07 -> busy stays 1, tx_byte=8'h08 next cycle; d_in toggled 1 cycle before start -> snapshot holds the pre-toggle value (2-flop latency).

Source files
------------

// File: rtl/spi_frame_sequencer_if.sv
// Byte-level link between the SPI shifter and the frame sequencer.
//   master : SPI byte shifter (drives frame/byte strobes and received bytes, takes tx_byte)
//   slave  : frame sequencer (consumes strobes, supplies tx_byte)
// Signals:
//   frame_start - 1-cycle pulse when SSEL goes active
//   frame_end   - 1-cycle pulse when SSEL goes inactive
//   tx_req      - 1-cycle pulse; shifter samples tx_byte this cycle
//   rx_valid    - 1-cycle pulse; rx_byte holds a complete byte
//   rx_byte     - received byte, MSB-first assembled
//   tx_byte     - byte presented to the shifter
interface spi_frame_sequencer_if;
  logic       frame_start;
  logic       frame_end;
  logic       tx_req;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;

  modport master (
    output frame_start, frame_end, tx_req, rx_valid, rx_byte,
    input  tx_byte
  );

  modport slave (
    input  frame_start, frame_end, tx_req, rx_valid, rx_byte,
    output tx_byte
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Frame-level controller for the byte-wide SPI slave datapath.
// Per frame it snapshots the synchronised sample pins and streams: sequence count, sample high
// byte, sample low byte, XOR checksum, then pad bytes. The first received byte of a frame is a
// command; bit 7 set writes bits 6:0 into ctrl.
// Ports:
//   clk     - system clock (shared with the shifter)
//   rst     - synchronous active-high reset
//   bus     - shifter link (slave side): strobes, rx_byte in, tx_byte out (registered)
//   d_in    - asynchronous sample pins, NBITS wide
//   ctrl    - 7-bit control register written by command
//   led     - ctrl[0]
//   seq_cnt - completed-frame counter, wraps at 255
//   busy    - high while a frame is in progress
module spi_frame_sequencer #(
  parameter int unsigned NBITS    = 12,
  parameter logic [7:0]  PAD_BYTE = 8'hAA
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_frame_sequencer_if.slave   bus,
  input  logic [NBITS-1:0]       d_in,
  output logic [6:0]             ctrl,
  output logic                   led,
  output logic [7:0]             seq_cnt,
  output logic                   busy
);

  typedef enum logic [2:0] {StIdle, StHdr, StDhi, StDlo, StCsum, StPad} state_e;

  state_e           state_q;
  logic [NBITS-1:0] sync1_q, sync2_q, snap_q;
  logic [7:0]       csum_q;
  logic [7:0]       tx_byte_q;
  logic [6:0]       ctrl_q;
  logic [7:0]       seq_cnt_q;
  logic             busy_q;
  logic             cmd_pending_q;  // first rx byte of the frame not yet seen

  logic       end_hit;
  logic [7:0] seq_after_end;
  logic [7:0] snap_hi, snap_lo;

  // frame_end only counts when a frame is actually open.
  assign end_hit       = bus.frame_end && (state_q != StIdle);
  // Combined end+start: the new header carries the already-incremented count.
  assign seq_after_end = end_hit ? seq_cnt_q + 8'd1 : seq_cnt_q;
  assign snap_hi       = 8'(snap_q >> 8);
  assign snap_lo       = snap_q[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sync1_q       <= '0;
      sync2_q       <= '0;
      snap_q        <= '0;
      csum_q        <= '0;
      tx_byte_q     <= PAD_BYTE;
      ctrl_q        <= '0;
      seq_cnt_q     <= '0;
      busy_q        <= 1'b0;
      cmd_pending_q <= 1'b0;
    end else begin
      sync1_q <= d_in;
      sync2_q <= sync1_q;

      if (bus.frame_start) begin
        // Any tx_req/rx_valid in this cycle is deliberately dropped.
        state_q       <= StHdr;
        busy_q        <= 1'b1;
        seq_cnt_q     <= seq_after_end;
        tx_byte_q     <= seq_after_end;
        csum_q        <= seq_after_end;
        snap_q        <= sync2_q;
        cmd_pending_q <= 1'b1;
      end else if (end_hit) begin
        state_q       <= StIdle;
        busy_q        <= 1'b0;
        seq_cnt_q     <= seq_after_end;
        tx_byte_q     <= PAD_BYTE;
        cmd_pending_q <= 1'b0;
      end else if (state_q != StIdle) begin
        if (bus.tx_req) begin
          unique case (state_q)
            StHdr: begin
              tx_byte_q <= snap_hi;
              csum_q    <= csum_q ^ snap_hi;
              state_q   <= StDhi;
            end
            StDhi: begin
              tx_byte_q <= snap_lo;
              csum_q    <= csum_q ^ snap_lo;
              state_q   <= StDlo;
            end
            StDlo: begin
              tx_byte_q <= csum_q;
              state_q   <= StCsum;
            end
            StCsum: begin
              tx_byte_q <= PAD_BYTE;
              state_q   <= StPad;
            end
            StPad, StIdle: begin
              tx_byte_q <= PAD_BYTE;
            end
            default: begin
              tx_byte_q <= PAD_BYTE;
            end
          endcase
        end
        if (bus.rx_valid && cmd_pending_q) begin
          cmd_pending_q <= 1'b0;
          if (bus.rx_byte[7]) begin
            ctrl_q <= bus.rx_byte[6:0];
          end
        end
      end
    end
  end

  assign bus.tx_byte = tx_byte_q;
  assign ctrl        = ctrl_q;
  assign led         = ctrl_q[0];
  assign seq_cnt     = seq_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
module tb_spi_frame_sequencer;

  logic        clk;
  logic        rst;
  logic [11:0] d_in;
  logic [6:0]  ctrl;
  logic        led;
  logic [7:0]  seq_cnt;
  logic        busy;

  int unsigned n_checks;
  int unsigned n_fail;

  spi_frame_sequencer_if bus ();

  spi_frame_sequencer #(
    .NBITS    (12),
    .PAD_BYTE (8'hAA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .d_in    (d_in),
    .ctrl    (ctrl),
    .led     (led),
    .seq_cnt (seq_cnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe pattern: set at negedge, consumed at the next posedge, cleared at the
  // following negedge where outputs are then sampled.
  task automatic pulse(input logic fs, input logic fe, input logic tr, input logic rv,
                       input logic [7:0] rb);
    @(negedge clk);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.tx_req      = tr;
    bus.rx_valid    = rv;
    bus.rx_byte     = rb;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.tx_req      = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_tx"},   bus.tx_byte, 8'hAA);
    check_eq({tag, "_ctrl"}, ctrl,        7'h00);
    check_eq({tag, "_led"},  led,         1'b0);
    check_eq({tag, "_seq"},  seq_cnt,     8'h00);
    check_eq({tag, "_busy"}, busy,        1'b0);
  endtask

  logic [7:0] exp_seq1 [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_seq1 = '{8'h00, 8'h0A, 8'h5C, 8'h56, 8'hAA};
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.tx_req      = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = 8'h00;
    d_in = 12'hA5C;
    rst  = 1'b1;
    idle(3);
    rst = 1'b0;
    check_reset_state("reset");

    // 1: basic frame, sample held long enough to pass the synchroniser
    idle(4);
    pulse(1, 0, 0, 0, 8'h00);
    check_eq("t1_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t1_byte%0d", i), bus.tx_byte, exp_seq1[i]);
      pulse(0, 0, 1, 0, 8'h00);
    end
    check_eq("t1_pad_hold", bus.tx_byte, 8'hAA);
    pulse(0, 1, 0, 0, 8'h00);
    check_eq("t1_seq", seq_cnt, 8'h01);
    check_eq("t1_busy_end", busy, 1'b0);
    check_eq("t1_tx_end", bus.tx_byte, 8'hAA);

    // 2: command parse; first byte alongside a tx_req, second byte ignored
    pulse(1, 0, 0, 0, 8'h00);
    check_eq("t2_hdr", bus.tx_byte, 8'h01);
    pulse(0, 0, 1, 1, 8'h81);
    check_eq("t2_ctrl", ctrl, 7'h01);
    check_eq("t2_led", led, 1'b1);
    check_eq("t2_tx_with_rx", bus.tx_byte, 8'h0A);
    pulse(0, 0, 0, 1, 8'h80);
    check_eq("t2_ctrl_2nd_ignored", ctrl, 7'h01);
    pulse(0, 1, 0, 0, 8'h00);
    pulse(1, 0, 0, 0, 8'h00);
    pulse(0, 0, 0, 1, 8'h00);
    check_eq("t2_ctrl_readonly", ctrl, 7'h01);
    pulse(0, 1, 0, 0, 8'h00);
    check_eq("t2_seq", seq_cnt, 8'h03);

    // 4: short frame, then strobes while idle
    pulse(1, 0, 0, 0, 8'h00);
    check_eq("t4_hdr", bus.tx_byte, 8'h03);
    pulse(0, 0, 1, 0, 8'h00);
    pulse(0, 1, 0, 0, 8'h00);
    check_eq("t4_tx_idle", bus.tx_byte, 8'hAA);
    check_eq("t4_seq", seq_cnt, 8'h04);
    check_eq("t4_busy", busy, 1'b0);
    pulse(0, 0, 1, 0, 8'h00);
    check_eq("t4_idle_txreq", bus.tx_byte, 8'hAA);
    pulse(0, 0, 0, 1, 8'h83);
    check_eq("t4_idle_rx", ctrl, 7'h01);
    pulse(0, 1, 0, 0, 8'h00);
    check_eq("t4_idle_end_noinc", seq_cnt, 8'h04);

    // 5: reset while in DLO with ctrl=0x15
    pulse(1, 0, 0, 0, 8'h00);
    pulse(0, 0, 1, 1, 8'h95);
    pulse(0, 0, 1, 0, 8'h00);
    check_eq("t5_ctrl_set", ctrl, 7'h15);
    check_eq("t5_dlo_tx", bus.tx_byte, 8'h5C);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("t5_rst");
    pulse(0, 0, 1, 0, 8'h00);
    check_eq("t5_txreq_no_frame", bus.tx_byte, 8'hAA);

    // 3: 256 empty frames wrap the counter
    d_in = 12'h123;
    for (int i = 0; i < 256; i++) begin
      pulse(1, 0, 0, 0, 8'h00);
      pulse(0, 1, 0, 0, 8'h00);
    end
    check_eq("t3_wrap", seq_cnt, 8'h00);
    pulse(1, 0, 0, 0, 8'h00);
    check_eq("t3_hdr257", bus.tx_byte, 8'h00);
    pulse(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      pulse(1, 0, 0, 0, 8'h00);
      pulse(0, 1, 0, 0, 8'h00);
    end
    check_eq("t6_pre_seq", seq_cnt, 8'h07);

    // 6: back-to-back end+start, sample toggled one cycle before the start
    pulse(1, 0, 0, 0, 8'h00);
    check_eq("t6_hdr7", bus.tx_byte, 8'h07);
    @(negedge clk);
    d_in = 12'hFED;
    pulse(1, 1, 0, 0, 8'h00);
    check_eq("t6_busy", busy, 1'b1);
    check_eq("t6_hdr8", bus.tx_byte, 8'h08);
    check_eq("t6_seq", seq_cnt, 8'h08);
    pulse(0, 0, 1, 0, 8'h00);
    check_eq("t6_snap_hi", bus.tx_byte, 8'h01);
    pulse(0, 0, 1, 0, 8'h00);
    check_eq("t6_snap_lo", bus.tx_byte, 8'h23);
    pulse(0, 0, 1, 0, 8'h00);
    check_eq("t6_csum", bus.tx_byte, 8'h2A);
    pulse(0, 1, 0, 0, 8'h00);
    check_eq("t6_seq_end", seq_cnt, 8'h09);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
